// File: rtl/trng_collector.sv
// Collector for the ring-oscillator TRNG core: warms the core up, von Neumann debiases its
// raw samples, runs a repetition-count health test and packs bits LSB-first into words.
//
// state   | meaning
// IDLE    | core disabled, waiting for enable
// WARMUP  | core enabled, waiting for oscillator start-up
// COLLECT | sampling, debiasing and packing bits
// FULL    | complete word presented on data/valid
// ERROR   | health test tripped; sticky until enable drops
module trng_collector #(
  parameter int WIDTH         = 32,
  parameter int WARMUP_CYCLES = 16,
  parameter int REP_LIMIT     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             trng_bit,
  output logic             trng_en,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             error
);

  localparam int BCW = $clog2(WIDTH);
  localparam int WCW = $clog2(WARMUP_CYCLES);
  localparam int RCW = $clog2(REP_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, WARMUP, COLLECT, FULL, ERROR} state_t;

  state_t           state, state_nxt;
  logic [WCW-1:0]   warm_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic             phase;
  logic             first_bit;
  logic             prev_bit;
  logic             first_flag;
  logic [RCW-1:0]   rep_cnt, rep_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             sample_en, emit, rep_trip, word_done;
  logic             trng_en_nxt, valid_nxt, error_nxt;

  always_comb begin
    sample_en = (state == COLLECT) && enable;
    emit      = sample_en && phase && (first_bit != trng_bit);
    rep_nxt   = (first_flag || (trng_bit != prev_bit)) ? RCW'(1) : rep_cnt + RCW'(1);
    rep_trip  = sample_en && (rep_nxt == RCW'(REP_LIMIT));
    word_done = emit && (bit_cnt == BCW'(WIDTH - 1));
    acc_nxt   = acc;
    // a 10 pair emits 1 and a 01 pair emits 0, i.e. the emitted bit is the first of the pair
    acc_nxt[bit_cnt] = first_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WARMUP;
        WARMUP:  if (warm_cnt == '0) state_nxt = COLLECT;
        COLLECT: begin
          if (rep_trip)       state_nxt = ERROR;
          else if (word_done) state_nxt = FULL;
        end
        FULL:    if (valid && ready) state_nxt = COLLECT;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state so they register on the same edge as the state
  always_comb begin
    trng_en_nxt = (state_nxt == WARMUP) || (state_nxt == COLLECT) || (state_nxt == FULL);
    valid_nxt   = (state_nxt == FULL);
    error_nxt   = (state_nxt == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trng_en    <= 1'b0;
      valid      <= 1'b0;
      error      <= 1'b0;
      data       <= '0;
      warm_cnt   <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      first_bit  <= 1'b0;
      prev_bit   <= 1'b0;
      first_flag <= 1'b0;
      rep_cnt    <= '0;
      acc        <= '0;
    end else begin
      trng_en <= trng_en_nxt;
      valid   <= valid_nxt;
      error   <= error_nxt;

      if ((state_nxt == WARMUP) && (state != WARMUP))
        warm_cnt <= WCW'(WARMUP_CYCLES - 1);
      else if ((state == WARMUP) && (warm_cnt != '0))
        warm_cnt <= warm_cnt - WCW'(1);

      if (!enable || rep_trip) begin
        bit_cnt    <= '0;
        phase      <= 1'b0;
        acc        <= '0;
        rep_cnt    <= '0;
        prev_bit   <= 1'b0;
        first_flag <= 1'b0;
      end else if ((state == WARMUP) && (state_nxt == COLLECT)) begin
        bit_cnt    <= '0;
        phase      <= 1'b0;
        acc        <= '0;
        rep_cnt    <= '0;
        first_flag <= 1'b1;
      end else if ((state == FULL) && (state_nxt == COLLECT)) begin
        // repetition history carries across the handshake
        bit_cnt <= '0;
        phase   <= 1'b0;
        acc     <= '0;
      end else if (sample_en) begin
        phase      <= ~phase;
        rep_cnt    <= rep_nxt;
        prev_bit   <= trng_bit;
        first_flag <= 1'b0;
        if (!phase) first_bit <= trng_bit;
        if (emit) begin
          if (word_done) begin
            data    <= acc_nxt;
            bit_cnt <= '0;
            acc     <= '0;
          end else begin
            acc     <= acc_nxt;
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector (WIDTH=8, WARMUP_CYCLES=4, REP_LIMIT=16).
// Edge counts are taken from the first clock edge that sees enable=1 (or the handshake edge).
module tb_trng_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       trng_bit;
  logic       trng_en;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       error;

  int n_chk = 0;
  int n_err = 0;
  int ecnt;
  int rise_at;

  trng_collector #(.WIDTH(8), .WARMUP_CYCLES(4), .REP_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trng_bit(trng_bit), .trng_en(trng_en),
    .data(data), .valid(valid), .ready(ready), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b);
    trng_bit = b;
    @(posedge clk);
    #1;
    ecnt++;
    if (valid && (rise_at < 0)) rise_at = ecnt;
  endtask

  task automatic mark();
    ecnt    = 0;
    rise_at = -1;
  endtask

  task automatic handshake();
    ready = 1'b1;
    step(1'b0);
    ready = 1'b0;
  endtask

  // feeds n pairs, each pair given as {first, second}
  task automatic pairs(input logic [1:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      step(p[1]);
      step(p[0]);
    end
  endtask

  logic [1:0] mix [14];

  initial begin
    reset = 1'b1; enable = 1'b1; trng_bit = 1'b0; ready = 1'b0;
    mark();

    // 1: reset held with enable high and trng_bit toggling
    for (int i = 0; i < 4; i++) step(i[0]);
    check("rst_trng_en", trng_en, 0);
    check("rst_valid", valid, 0);
    check("rst_error", error, 0);
    check("rst_data", data, 8'h00);
    reset = 1'b0;
    mark();
    step(1'b1);
    check("first_edge_trng_en", trng_en, 1);

    // 2: warmup then pairs 10,01 -> 0x55
    for (int i = 0; i < 4; i++) step(i[0]);
    check("warmup_no_valid", valid, 0);
    pairs(2'b10, 1);
    for (int i = 0; i < 3; i++) begin
      pairs(2'b01, 1);
      pairs(2'b10, 1);
    end
    pairs(2'b01, 1);
    check("w1_rise_edges", rise_at - 1, 20);
    check("w1_data", data, 8'h55);
    for (int i = 0; i < 6; i++) begin
      step(i[0]);
      check("w1_hold", {valid, data}, 9'h155);
    end

    // 4: one-cycle ready pulse, then pairs 01 x8 -> 0x00
    handshake();
    check("hs1_valid_low", valid, 0);
    mark();
    pairs(2'b01, 8);
    check("w2_rise_edges", rise_at, 16);
    check("w2_data", data, 8'h00);
    handshake();
    check("hs2_valid_low", valid, 0);

    // 3: eight 10 pairs interleaved with six 00/11 pairs -> 0xFF after 28 samples
    mix = '{2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10,
            2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
    mark();
    for (int i = 0; i < 14; i++) pairs(mix[i], 1);
    check("w3_rise_edges", rise_at, 28);
    check("w3_data", data, 8'hFF);
    handshake();

    // 5: stuck-at-1 trips the repetition test on the 16th sample
    for (int i = 0; i < 15; i++) step(1'b1);
    check("rep15_no_error", error, 0);
    step(1'b1);
    check("rep16_error", error, 1);
    check("rep16_trng_en", trng_en, 0);
    check("rep16_valid", valid, 0);
    step(1'b0);
    step(1'b1);
    check("error_sticky", error, 1);
    enable = 1'b0;
    step(1'b0);
    check("dis_error_clr", error, 0);
    check("dis_trng_en", trng_en, 0);
    enable = 1'b1;
    step(1'b1);
    check("reen_trng_en", trng_en, 1);

    // 6: three emitted zeros, disable, re-enable, 10 x8 -> 0xFF on the full schedule
    for (int i = 0; i < 4; i++) step(i[0]);
    pairs(2'b01, 3);
    enable = 1'b0;
    step(1'b1);
    check("dis2_valid", valid, 0);
    check("dis2_trng_en", trng_en, 0);
    check("dis2_data_kept", data, 8'hFF);
    enable = 1'b1;
    mark();
    step(1'b0);
    for (int i = 0; i < 4; i++) step(i[0]);
    pairs(2'b10, 8);
    check("w4_rise_edges", rise_at - 1, 20);
    check("w4_data", data, 8'hFF);

    // asynchronous reset mid-COLLECT, checked before the next clock edge
    handshake();
    step(1'b1);
    step(1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_trng_en", trng_en, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_error", error, 0);
    check("async_rst_data", data, 8'h00);
    step(1'b0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
